// File: rtl/fetch_queue.sv
// Show-ahead circular fetch queue carrying instruction, PC and branch-prediction metadata to decode.
// Define FETCH_QUEUE_STATS_EN to compile in the full-stall and flush statistics counters.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int BHR_W = 6
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    input  logic [31:0]                in_instr,
    input  logic [31:0]                in_pc,
    input  logic [31:0]                in_btb_address,
    input  logic                       in_taken,
    input  logic [BHR_W-1:0]           in_bhr,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [31:0]                out_instr,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_btb_address,
    output logic                       out_taken,
    output logic [BHR_W-1:0]           out_bhr,
    input  logic                       out_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count,
    output logic [31:0]                full_stall_count,
    output logic [31:0]                flush_count,
    input  logic                       full_stall_reset,
    input  logic                       flush_reset
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 97 + BHR_W;

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] occ;
    logic [EW-1:0] mem [DEPTH];
    logic          push;
    logic          pop;

    assign count     = occ;
    assign in_ready  = (occ < CW'(DEPTH));
    assign out_valid = (occ != '0) & ~flush;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign {out_instr, out_pc, out_btb_address, out_taken, out_bhr} = mem[head];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (push) tail <= tail + AW'(1);
            if (pop)  head <= head + AW'(1);
            case ({push, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Storage is never reset; a write is suppressed whenever the pointers are being cleared.
    always_ff @(posedge clk) begin
        if (push && reset_n && !flush)
            mem[tail] <= {in_instr, in_pc, in_btb_address, in_taken, in_bhr};
    end

`ifdef FETCH_QUEUE_STATS_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (full_stall_reset)
                stall_cnt <= '0;
            else if (in_valid && !in_ready && !flush)
                stall_cnt <= sat_inc(stall_cnt);
            if (flush_reset)
                flush_cnt <= '0;
            else if (flush)
                flush_cnt <= sat_inc(flush_cnt);
        end
    end

    assign full_stall_count = stall_cnt;
    assign flush_count      = flush_cnt;
`else
    logic unused_stats_resets;
    assign unused_stats_resets = full_stall_reset ^ flush_reset;
    assign full_stall_count    = '0;
    assign flush_count         = '0;
`endif

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter: DEPTH, default 4, meaning entry count; SHALL be a power of two, 2 to 16.
REQ-002 Parameter: BHR_W, default 6, meaning width of carried branch-history field.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 in_valid  input  1  fetch stage presents an instruction.
REQ-006 in_instr / in_pc / in_btb_address  input  32 each  fetched word, its PC, predicted target.
REQ-007 in_taken  input  1; in_bhr  input  BHR_W  prediction metadata from fetch.
REQ-008 in_ready  output  1  queue can accept; push = in_valid & in_ready.
REQ-009 out_valid  output  1  head entry available to decode.
REQ-010 out_instr / out_pc / out_btb_address  output  32 each; out_taken 1; out_bhr BHR_W  head entry fields.
REQ-011 out_ready  input  1  decode consumes; pop = out_valid & out_ready.
REQ-012 flush  input  1  execute-stage redirect (mispredict); discards all contents.
REQ-013 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-014 full_stall_count / flush_count  output  32 each  statistics (see Configuration).
REQ-015 full_stall_reset / flush_reset  input  1 each  active-high synchronous clear of statistics.

Function
REQ-016 Storage SHALL be a circular buffer with head/tail pointers wrapping modulo DEPTH plus an occupancy counter.
REQ-017 in_ready SHALL equal (count < DEPTH); no push-through when full, even with a simultaneous pop.
REQ-018 out_valid SHALL equal (count != 0) & ~flush; out_* fields SHALL be the head entry, combinationally (show-ahead).
REQ-019 Push-to-visible latency SHALL be exactly one cycle; no same-cycle bypass when empty.
REQ-020 Push only: entry written at tail, tail+1, count+1; pop only: head+1, count-1.
REQ-021 Simultaneous push and pop: both pointers advance, count unchanged.
REQ-022 Entries SHALL emerge in push order with all five fields unmodified.
REQ-023 Flush SHALL take priority over push and pop: next cycle head=tail=0, count=0; that cycle's in_* data discarded.
REQ-024 out_* data values while out_valid=0 are don't-care; out_valid SHALL never be 1 with count=0.
REQ-025 Pop with count=0 and push with count=DEPTH SHALL be impossible by construction (gated by out_valid/in_ready).

Reset
REQ-026 When reset_n=0 at a clock edge: head, tail, count SHALL be 0; next cycle out_valid=0, in_ready=1.
REQ-027 Reset SHALL take priority over flush, push, pop; in-flight entries discarded mid-operation.
REQ-028 Reset SHALL clear both statistics counters to 0 when compiled in.
REQ-029 Entry storage SHALL NOT require reset.

Configuration
REQ-030 Macro FETCH_QUEUE_STATS_EN SHALL compile in the statistics counters.
REQ-031 With macro: full_stall_count +1 per cycle with in_valid & ~in_ready & ~flush; flush_count +1 per cycle with flush=1; both saturate at 0xFFFFFFFF.
REQ-032 With macro: the corresponding *_reset input SHALL zero its counter next cycle, priority over increment.
REQ-033 Without macro: both count outputs SHALL be constant 0, reset inputs ignored, no counter flops.

Verification
REQ-034 Reset, then push PC 0x60,0x64,0x68 with out_ready=0 -> count=3, out_pc=0x60, in_ready=1.
REQ-035 DEPTH=4: push 4 entries, hold in_valid=1, out_ready=0 for 3 cycles -> in_ready=0, count=4, full_stall_count=3 (macro on), 0 (macro off).
REQ-036 Full queue, in_valid=1 and out_ready=1 one cycle -> pop only, count=3; next cycle push accepted, count=4, FIFO order intact over 10 wraps.
REQ-037 count=2, flush=1 with in_valid=1 -> out_valid=0 that cycle; next cycle count=0, flush_count=1; next push appears alone at head.
REQ-038 Count=3, reset_n=0 with flush=1 and in_valid=1 -> next cycle count=0, out_valid=0, stats=0; in_instr 0x00000013 pushed after reset emerges with in_taken/in_bhr/in_btb_address intact.
